sn74161: RTL
============

# sn74161

Pin-level behavioural model of the TTL SN74161 synchronous 4-bit binary counter, with asynchronous clear, synchronous parallel load, and ripple-carry output. It is the upstream stage of the sn74154 decoder model. QA..QD drive the decoder's A..D pins (P23, P22, P21, P20), so the decoder's 16 active-low outputs are scanned one per enabled clock. RCO is available to cascade a second counter or to gate the decoder's G1/G2.

## Interface
Parameters: none (fixed 4-bit device).

Clock and reset are decided as follows: one clock, P2 (CLK, rising edge); reset P1 (CLR), asynchronous, active-low.

- P2  input  1  CLK, rising-edge clock
- P1  input  1  CLR, asynchronous active-low clear
- P3  input  1  A, parallel data bit 0
- P4  input  1  B, parallel data bit 1
- P5  input  1  C, parallel data bit 2
- P6  input  1  D, parallel data bit 3
- P7  input  1  ENP, count enable P
- P10 input  1  ENT, count enable T (also gates RCO)
- P9  input  1  LOAD, synchronous active-low load
- P8  input  1  GND, must be 0 for operation
- P16 input  1  VCC, must be 1 for operation
- P14 output 1  QA, count bit 0 (LSB)
- P13 output 1  QB, count bit 1
- P12 output 1  QC, count bit 2
- P11 output 1  QD, count bit 3 (MSB)
- P15 output 1  RCO, ripple carry out

## Operation
- Internal state Q[3:0] = {QD,QC,QB,QA}. Outputs are registered copies of Q, except RCO.
- The device is powered when P16==1'b1 and P8==1'b0. When unpowered, all clock edges and clear events are ignored and Q holds.
- Priority order, highest first:
  - CLR (P1) low while powered: Q=4'b0000 immediately, independent of the clock. Q stays 0 while P1 is low, including across clock edges.
  - Rising P2 with P1 high and LOAD (P9) == 0: Q <= {P6,P5,P4,P3}. ENP and ENT are ignored.
  - Rising P2 with P1 high, P9==1, P7==1 and P10==1: Q <= Q+1 mod 16, so 4'b1111 wraps to 4'b0000.
  - Any other rising edge: Q holds. This includes ENP==0 or ENT==0, and any control input at x or z.
- RCO (P15) = P10 & QA & QB & QC & QD. It is combinational and not gated by ENP or LOAD. It re-evaluates on any change of P10 or Q.
- Load and count are mutually exclusive by priority; a simultaneous LOAD=0 with ENP=ENT=1 loads.
- Clear released on the same timestep as a rising P2: the clear wins and Q=0 after that edge. The first count occurs on the next edge.
- Power becoming valid while P1 is low: Q is cleared on the next P1 or P2 event. When power becomes valid, outputs hold their previous values until then.

## Timing
- Zero-delay model. Q and RCO update in the same simulation timestep as the rising P2 or falling P1.
- Reset values: P14=P13=P12=P11=0. P15=0, since Q≠4'b1111.
- Count and load latency is one clock. The new value is visible immediately after the edge and is stable for the whole following cycle.
- RCO is high for exactly one count cycle per 16 while ENT=1 and counting: the cycle in which Q=15. It falls after the wrap edge.
- Setup and hold are not modelled. Inputs are sampled at the edge as blocking reads of the current pin values.
- Cascading: RCO of stage n drives ENT of stage n+1, with ENP tied high on both. The upper stage increments only on the edge where the lower stage wraps.

## Test plan
- Reset: power on (P16=1, P8=0), P1=0, toggle P2 three times → Q=0000 and P15=0 throughout. Raise P1 with ENP=ENT=LOAD=1 → Q reads 1,2,3 after the next three edges.
- Count and wrap: from Q=0 with ENP=ENT=LOAD=1, apply 17 edges → Q steps 1..15 then 0 then 1. P15=1 only while Q=15.
- Load priority: Q=5, DCBA=4'b1010, LOAD=0, ENP=ENT=1, one edge → Q=1010. LOAD=1 with ENP=0, two edges → Q holds at 1010.
- RCO gating: load 1111, ENP=0, ENT=1 → P15=1. Drop ENT to 0 → P15=0 with no clock edge. An edge with ENT=0 → Q holds at 1111.
- Async clear mid-count: at Q=9, drive P1=0 between edges → Q=0 immediately. Release P1 on the same timestep as a rising P2 → Q=0 after that edge, then Q=1 after the next.
- Unpowered and decoder chain: with P16=0, edges and P1=0 do not change Q. Restore power, clear, then count with QA..QD wired to sn74154 A..D and G1=G2=0 → exactly one decoder output low per cycle, in order P1..P11, P13..P17.

Source files
------------

// File: rtl/sn74161.sv
// sn74161 - pin-level behavioural model of the TTL SN74161 synchronous 4-bit
// binary counter with asynchronous clear, synchronous parallel load and
// ripple-carry output. QA..QD typically drive an sn74154 decoder's A..D pins.
//
// Ports (device pin numbers):
//   P2  CLK  rising-edge clock
//   P1  CLR  asynchronous active-low clear
//   P3..P6   parallel data A..D (A = LSB)
//   P7  ENP  count enable P
//   P10 ENT  count enable T, also gates RCO
//   P9  LOAD synchronous active-low load
//   P8  GND  must be 0 for operation
//   P16 VCC  must be 1 for operation
//   P14,P13,P12,P11  QA..QD count outputs (QA = LSB)
//   P15 RCO  ripple carry out = ENT & (Q == 15)
module sn74161 (
  input  logic P2,
  input  logic P1,
  input  logic P3,
  input  logic P4,
  input  logic P5,
  input  logic P6,
  input  logic P7,
  input  logic P10,
  input  logic P9,
  input  logic P8,
  input  logic P16,
  output logic P14,
  output logic P13,
  output logic P12,
  output logic P11,
  output logic P15
);

  logic [3:0] q_q;
  logic [3:0] q_d;
  logic       pwr;
  logic       load_en;
  logic       cnt_en;

  // Compares against explicit constants so that x/z on any supply or
  // control pin evaluates as "not asserted" and the counter holds.
  assign pwr     = (P16 == 1'b1) && (P8 == 1'b0);
  assign load_en = (P9 == 1'b0);
  assign cnt_en  = (P9 == 1'b1) && (P7 == 1'b1) && (P10 == 1'b1);

  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = {P6, P5, P4, P3};
    end else if (cnt_en) begin
      q_d = q_q + 4'd1;
    end
  end

  // A clock edge seen while CLR is still low lands in the clear branch, so
  // the counter stays at zero across edges and a supply that has just come
  // up clears on the next CLK or CLR event. Unpowered, nothing changes.
  always_ff @(posedge P2 or negedge P1) begin
    if (!P1) begin
      if (pwr) begin
        q_q <= 4'b0000;
      end
    end else if (pwr) begin
      q_q <= q_d;
    end
  end

  assign P14 = q_q[0];
  assign P13 = q_q[1];
  assign P12 = q_q[2];
  assign P11 = q_q[3];

  // Combinational carry: follows ENT and Q, independent of ENP and LOAD.
  assign P15 = P10 & (&q_q);

endmodule
